// File: rtl/p6_pkg.sv
// Shared types and constants for the r_int_interp interpolating sample stage.
package p6_pkg;

    localparam int unsigned WIN_DEFAULT = 16;

    localparam logic MODE_ZERO = 1'b0;
    localparam logic MODE_HOLD = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Per-channel output source for the next slot.
    typedef enum logic [1:0] {
        SEL_ZERO   = 2'd0,
        SEL_SAMPLE = 2'd1,
        SEL_HOLD   = 2'd2
    } slot_sel_t;

endpackage

// File: rtl/r_int_slot.sv
// Per-channel slot generator: holds the accepted sample and registers the
// selected slot value (new sample, zero or held sample).
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   i_load    - capture i_sample into the hold register
//   i_sel     - source of the next output slot
//   i_sample  - incoming channel sample
//   o_data    - registered slot value
module r_int_slot
    import p6_pkg::*;
#(
    parameter int unsigned WIN = WIN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  slot_sel_t       i_sel,
    input  logic [WIN-1:0]  i_sample,
    output logic [WIN-1:0]  o_data
);

    logic [WIN-1:0] r_hold;
    logic [WIN-1:0] r_data;

    // Hold register and output slot register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
            r_data <= '0;
        end else begin
            if (i_load) begin
                r_hold <= i_sample;
            end
            case (i_sel)
                SEL_SAMPLE: r_data <= i_sample;
                SEL_HOLD:   r_data <= r_hold;
                default:    r_data <= '0;
            endcase
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/r_int_interp.sv
// Multi-channel interpolating sample stage. Each accepted sample produces
// Lq output slots: the sample, then Lq-1 zeros or held copies.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   data_in   - NCH packed signed samples, channel k at [k*WIN +: WIN]
//   val_in    - input sample valid
//   l_factor  - interpolation factor (0 treated as 1), sampled on acceptance
//   mode      - 0 zero-stuff, 1 zero-order hold, sampled on acceptance
//   ready     - combinational: a val_in this cycle is accepted
//   data_out  - registered output slots
//   val_out   - registered slot valid
//   count     - accepted-sample count (wraps)
//   overrun   - one-cycle pulse after a val_in that was not accepted
module r_int_interp
    import p6_pkg::*;
#(
    parameter int unsigned WIN = WIN_DEFAULT,
    parameter int unsigned NCH = 2,
    parameter int unsigned LW  = 5,
    parameter int unsigned CW  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH*WIN-1:0] data_in,
    input  logic               val_in,
    input  logic [LW-1:0]      l_factor,
    input  logic               mode,
    output logic               ready,
    output logic [NCH*WIN-1:0] data_out,
    output logic               val_out,
    output logic [CW-1:0]      count,
    output logic               overrun
);

    state_t          r_state;
    logic [LW-1:0]   r_phase;
    logic [LW-1:0]   r_lq;
    logic            r_mode;
    logic [CW-1:0]   r_count;
    logic            r_overrun;
    logic            r_val_out;

    logic            w_ready;
    logic            w_acc;
    logic            w_last;
    logic [LW-1:0]   w_lnew;
    slot_sel_t       w_sel;

    // r_phase is the index of the next slot to emit; once it equals Lq the
    // last slot of the burst is on data_out and a new sample may follow.
    assign w_last  = (r_state == ST_RUN) && (r_phase == r_lq);
    assign w_ready = (r_state == ST_IDLE) || w_last;
    assign w_acc   = val_in && w_ready;
    assign w_lnew  = (l_factor == '0) ? LW'(1) : l_factor;

    // Slot source selection shared by all channels.
    always_comb begin
        w_sel = SEL_ZERO;
        if (w_acc) begin
            w_sel = SEL_SAMPLE;
        end else if ((r_state == ST_RUN) && !w_last) begin
            w_sel = (r_mode == MODE_HOLD) ? SEL_HOLD : SEL_ZERO;
        end
    end

    // Burst FSM, phase, count and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_phase   <= '0;
            r_lq      <= '0;
            r_mode    <= MODE_ZERO;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_val_out <= 1'b0;
        end else begin
            r_overrun <= val_in && !w_ready;
            if (w_acc) begin
                r_lq      <= w_lnew;
                r_mode    <= mode;
                r_count   <= r_count + CW'(1);
                r_phase   <= LW'(1);
                r_state   <= ST_RUN;
                r_val_out <= 1'b1;
            end else if (r_state == ST_RUN) begin
                if (w_last) begin
                    r_state   <= ST_IDLE;
                    r_phase   <= '0;
                    r_val_out <= 1'b0;
                end else begin
                    r_phase   <= r_phase + LW'(1);
                    r_val_out <= 1'b1;
                end
            end else begin
                r_val_out <= 1'b0;
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_ch
            r_int_slot #(.WIN(WIN)) u_slot (
                .clk      (clk),
                .rst      (rst),
                .i_load   (w_acc),
                .i_sel    (w_sel),
                .i_sample (data_in[k*WIN +: WIN]),
                .o_data   (data_out[k*WIN +: WIN])
            );
        end
    endgenerate

    assign ready   = w_ready;
    assign val_out = r_val_out;
    assign count   = r_count;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_r_int_interp.sv
// Directed self-checking bench for r_int_interp (WIN=16, NCH=2, LW=5, CW=12).
module tb_r_int_interp;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        val_in;
    logic [4:0]  l_factor;
    logic        mode;
    logic        ready;
    logic [31:0] data_out;
    logic        val_out;
    logic [11:0] count;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    r_int_interp #(.WIN(16), .NCH(2), .LW(5), .CW(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .val_in   (val_in),
        .l_factor (l_factor),
        .mode     (mode),
        .ready    (ready),
        .data_out (data_out),
        .val_out  (val_out),
        .count    (count),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check one output slot.
    task automatic slot(input string tag, input logic [31:0] d, input logic v);
        chk({tag, "_data"}, data_out, d);
        chk({tag, "_val"}, {31'd0, val_out}, {31'd0, v});
    endtask

    // Drive a sample (val_in pulse) for one cycle.
    task automatic send(input logic [31:0] d, input logic [4:0] l, input logic m);
        data_in  = d;
        l_factor = l;
        mode     = m;
        val_in   = 1'b1;
        tick();
        val_in   = 1'b0;
    endtask

    localparam logic [31:0] S_A = 32'hFFFB_0064;   // ch1=-5, ch0=100

    initial begin
        rst = 1'b1; data_in = '0; val_in = 1'b0; l_factor = 5'd1; mode = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        slot("rst", 32'h0, 1'b0);
        chk("rst_count", {20'd0, count}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);

        // 1: zero-stuff, L=4
        send(S_A, 5'd4, 1'b0);
        slot("t1_s0", S_A, 1'b1);
        chk("t1_count", {20'd0, count}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            slot("t1_zero", 32'h0, 1'b1);
        end
        tick();
        slot("t1_idle", 32'h0, 1'b0);
        chk("t1_count_end", {20'd0, count}, 32'd1);

        // 2: zero-order hold, L=4, ready low for three cycles
        send(S_A, 5'd4, 1'b1);
        slot("t2_s0", S_A, 1'b1);
        chk("t2_rdy0", {31'd0, ready}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            slot("t2_hold", S_A, 1'b1);
            chk("t2_rdy", {31'd0, ready}, (i == 3) ? 32'd1 : 32'd0);
        end
        tick();
        slot("t2_idle", 32'h0, 1'b0);
        chk("t2_count", {20'd0, count}, 32'd2);

        // 3: back-to-back L=3 bursts, no gaps
        for (int s = 1; s <= 3; s++) begin
            send({16'(s), 16'(s)}, 5'd3, 1'b0);
            slot("t3_s0", {16'(s), 16'(s)}, 1'b1);
            chk("t3_ovr0", {31'd0, overrun}, 32'd0);
            tick();
            slot("t3_z1", 32'h0, 1'b1);
            chk("t3_ovr1", {31'd0, overrun}, 32'd0);
            tick();
            slot("t3_z2", 32'h0, 1'b1);
            chk("t3_ovr2", {31'd0, overrun}, 32'd0);
        end
        tick();
        slot("t3_idle", 32'h0, 1'b0);
        chk("t3_count", {20'd0, count}, 32'd5);

        // 4: val_in during an L=4 burst is dropped
        send(32'h1234_5678, 5'd4, 1'b1);
        slot("t4_s0", 32'h1234_5678, 1'b1);
        data_in = 32'hDEAD_BEEF; l_factor = 5'd2; mode = 1'b0; val_in = 1'b1;
        #1;
        chk("t4_rdy", {31'd0, ready}, 32'd0);
        tick();
        val_in = 1'b0;
        slot("t4_s1", 32'h1234_5678, 1'b1);
        chk("t4_ovr", {31'd0, overrun}, 32'd1);
        chk("t4_count", {20'd0, count}, 32'd6);
        tick();
        slot("t4_s2", 32'h1234_5678, 1'b1);
        chk("t4_ovr_end", {31'd0, overrun}, 32'd0);
        tick();
        slot("t4_s3", 32'h1234_5678, 1'b1);
        tick();
        slot("t4_idle", 32'h0, 1'b0);
        chk("t4_count_end", {20'd0, count}, 32'd6);

        // 5: L=0 and L=1 pass-through, val_in every cycle
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 5; i++) begin
                data_in  = 32'h0101_0101 * 32'(i + 1 + 5 * l);
                l_factor = 5'(l);
                mode     = 1'b0;
                val_in   = 1'b1;
                tick();
                slot("t5_pass", 32'h0101_0101 * 32'(i + 1 + 5 * l), 1'b1);
            end
            val_in = 1'b0;
            tick();
            slot("t5_idle", 32'h0, 1'b0);
            chk("t5_count", {20'd0, count}, 32'(11 + 5 * l));
        end

        // 6: reset mid-burst, then count wrap
        send(32'hAAAA_5555, 5'd8, 1'b1);
        tick(); tick();
        slot("t6_s2", 32'hAAAA_5555, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        slot("t6_rst", 32'h0, 1'b0);
        chk("t6_count", {20'd0, count}, 32'd0);
        chk("t6_ovr", {31'd0, overrun}, 32'd0);
        chk("t6_ready", {31'd0, ready}, 32'd1);
        data_in = 32'h0000_0001; l_factor = 5'd1; mode = 1'b0; val_in = 1'b1;
        for (int i = 0; i < 4095; i++) tick();
        chk("t6_count_max", {20'd0, count}, 32'd4095);
        tick();
        val_in = 1'b0;
        chk("t6_count_wrap", {20'd0, count}, 32'd0);
        chk("t6_ovr_end", {31'd0, overrun}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
